// File: rtl/count_down_sequencer_if.sv
// Control/counter-facing signal bundle for the count-down start sequencer.
interface count_down_sequencer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             go;
  logic             stop;
  logic             abort;
  logic             clear_err;
  logic [WIDTH-1:0] count_down_in;
  logic             count_down_start;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       runs;

  // Environment side: drives control and the counter value, observes status.
  modport master (
    output go, stop, abort, clear_err, count_down_in,
    input  count_down_start, busy, done, err, runs
  );

  // Sequencer side.
  modport slave (
    input  go, stop, abort, clear_err, count_down_in,
    output count_down_start, busy, done, err, runs
  );
endinterface

// File: rtl/count_down_sequencer.sv
// Issues a one-cycle start pulse to a count-down counter, then watches its
// value leave zero and return to zero. Reports done, sticky timeout error
// and a saturating completed-run count. All outputs are registered.
module count_down_sequencer #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned GAP         = 3,
  parameter int unsigned TIMEOUT     = 20,
  parameter int unsigned AUTO_REPEAT = 0
) (
  input  logic                   clk,
  input  logic                   areset_n,
  count_down_sequencer_if.slave  bus
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);
  localparam logic [WIDTH-1:0] ZERO     = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PULSE,
    S_ARM,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       runs_q, runs_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cd_zero;
  logic             to_hit;
  logic [TO_W-1:0]  to_inc;

  assign cd_zero = (bus.count_down_in == ZERO);
  assign to_hit  = (to_q >= TO_LAST);
  assign to_inc  = (to_q == TO_MAX) ? to_q : to_q + TO_W'(1);

  // State, counters and registered Moore outputs.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      to_q    <= '0;
      runs_q  <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      runs_q  <= runs_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, counter update and output decode of the next state.
  always_comb begin
    state_d = state_q;
    gap_d   = '0;
    to_d    = '0;
    runs_d  = runs_q;
    start_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = (GAP == 0) ? S_PULSE : S_GAP;
        end
      end
      S_GAP: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_PULSE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_PULSE: begin
        state_d = bus.abort ? S_IDLE : S_ARM;
      end
      S_ARM: begin
        to_d = to_inc;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!cd_zero) begin
          state_d = S_RUN;
        end else if (to_hit) begin
          state_d = S_ERR;
        end
      end
      S_RUN: begin
        to_d = to_inc;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (cd_zero) begin
          state_d = S_DONE;
        end else if (to_hit) begin
          state_d = S_ERR;
        end
      end
      S_DONE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if ((AUTO_REPEAT != 0) && !bus.stop) begin
          state_d = (GAP == 0) ? S_PULSE : S_GAP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        if (bus.clear_err) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // DONE lasts one cycle, so entering it counts exactly one run.
    if ((state_d == S_DONE) && (runs_q != 8'hFF)) begin
      runs_d = runs_q + 8'd1;
    end

    start_d = (state_d == S_PULSE);
    busy_d  = (state_d == S_GAP) || (state_d == S_PULSE) ||
              (state_d == S_ARM) || (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
  end

  assign bus.count_down_start = start_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.err              = err_q;
  assign bus.runs             = runs_q;

endmodule

// File: tb/tb_count_down_sequencer.sv
// Bench for count_down_sequencer: one instance without and one with
// auto-repeat, a vector table, directed corner sequences and random traffic
// checked every cycle against a sequence-level reference model.
module tb_count_down_sequencer;

  localparam int GAP_C     = 3;
  localparam int TIMEOUT_C = 20;

  // Reference phases: arm and run are one "wait" phase plus a left-zero flag.
  localparam int P_IDLE  = 0;
  localparam int P_GAP   = 1;
  localparam int P_PULSE = 2;
  localparam int P_WAIT  = 3;
  localparam int P_DONE  = 4;
  localparam int P_ERR   = 5;

  typedef struct {
    int ph;
    int t;
    bit left;
    int runs;
  } mdl_t;

  typedef struct {
    bit go;
    bit stop;
    bit abort;
    bit clr;
    int cdi;
  } in_t;

  typedef struct {
    bit          go;
    bit          abort;
    logic [3:0]  cdi;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mdl_t       m_a, m_b;
  bit         ren_a, ren_b;
  int         load_a, load_b;
  int         rv_a, rv_b;
  logic [3:0] man_a, man_b;

  count_down_sequencer_if #(.WIDTH(4)) ifa ();
  count_down_sequencer_if #(.WIDTH(4)) ifb ();

  count_down_sequencer #(
    .WIDTH(4), .GAP(GAP_C), .TIMEOUT(TIMEOUT_C), .AUTO_REPEAT(0)
  ) u_dut_a (
    .clk(clk), .areset_n(rst_n), .bus(ifa.slave)
  );

  count_down_sequencer #(
    .WIDTH(4), .GAP(GAP_C), .TIMEOUT(TIMEOUT_C), .AUTO_REPEAT(1)
  ) u_dut_b (
    .clk(clk), .areset_n(rst_n), .bus(ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pk(bit s, bit b, bit d, bit e, int r);
    return {20'd0, s, b, d, e, 8'(r)};
  endfunction

  function automatic logic [31:0] act_a();
    return pk(ifa.count_down_start, ifa.busy, ifa.done, ifa.err, int'(ifa.runs));
  endfunction

  function automatic logic [31:0] act_b();
    return pk(ifb.count_down_start, ifb.busy, ifb.done, ifb.err, int'(ifb.runs));
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.ph = P_IDLE; m.t = 0; m.left = 1'b0; m.runs = 0;
    return m;
  endfunction

  // One clock of the sequence rules applied to the inputs sampled at the edge.
  function automatic mdl_t mdl_step(mdl_t m_in, bit auto_rep, in_t i);
    mdl_t m;
    m = m_in;
    case (m.ph)
      P_IDLE: if (i.go) begin
        m.ph = (GAP_C > 0) ? P_GAP : P_PULSE;
        m.t  = 0;
      end
      P_GAP: if (i.abort) m.ph = P_IDLE;
             else begin
               m.t++;
               if (m.t == GAP_C) m.ph = P_PULSE;
             end
      P_PULSE: if (i.abort) m.ph = P_IDLE;
               else begin
                 m.ph = P_WAIT; m.t = 0; m.left = 1'b0;
               end
      P_WAIT: if (i.abort) m.ph = P_IDLE;
              else begin
                m.t++;
                if (m.left && i.cdi == 0) begin
                  m.ph   = P_DONE;
                  m.runs = (m.runs < 255) ? m.runs + 1 : 255;
                end else if (!m.left && i.cdi != 0) begin
                  m.left = 1'b1;
                end else if (m.t >= TIMEOUT_C) begin
                  m.ph = P_ERR;
                end
              end
      P_DONE: if (i.abort) m.ph = P_IDLE;
              else if (auto_rep && !i.stop) begin
                m.ph = (GAP_C > 0) ? P_GAP : P_PULSE;
                m.t  = 0;
              end else m.ph = P_IDLE;
      P_ERR: if (i.clr) m.ph = P_IDLE;
      default: m.ph = P_IDLE;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] mdl_out(mdl_t m);
    return pk(m.ph == P_PULSE,
              (m.ph == P_GAP) || (m.ph == P_PULSE) || (m.ph == P_WAIT),
              m.ph == P_DONE, m.ph == P_ERR, m.runs);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cdi();
    ifa.count_down_in = ren_a ? 4'(rv_a) : man_a;
    ifb.count_down_in = ren_b ? 4'(rv_b) : man_b;
  endtask

  task automatic clear_inputs();
    ifa.go = 1'b0; ifa.stop = 1'b0; ifa.abort = 1'b0; ifa.clear_err = 1'b0;
    ifb.go = 1'b0; ifb.stop = 1'b0; ifb.abort = 1'b0; ifb.clear_err = 1'b0;
  endtask

  // Advance one clock: step the models, the counter responders and compare.
  task automatic tick();
    in_t ia, ib;
    bit  sa, sb;
    ia.go = ifa.go; ia.stop = ifa.stop; ia.abort = ifa.abort;
    ia.clr = ifa.clear_err; ia.cdi = int'(ifa.count_down_in);
    ib.go = ifb.go; ib.stop = ifb.stop; ib.abort = ifb.abort;
    ib.clr = ifb.clear_err; ib.cdi = int'(ifb.count_down_in);
    sa = ifa.count_down_start;
    sb = ifb.count_down_start;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_a = mdl_rst();
      m_b = mdl_rst();
    end else begin
      m_a = mdl_step(m_a, 1'b0, ia);
      m_b = mdl_step(m_b, 1'b1, ib);
    end
    if (ren_a) begin
      if (sa) rv_a = load_a;
      else if (rv_a > 0) rv_a--;
    end
    if (ren_b) begin
      if (sb) rv_b = load_b;
      else if (rv_b > 0) rv_b--;
    end
    drive_cdi();
    check("model_a", act_a(), mdl_out(m_a));
    check("model_b", act_b(), mdl_out(m_b));
  endtask

  initial begin
    vec_t tbl [18];
    int   first_done, first_err, ndone, npulse, r252, zp;
    bit   found;

    tbl[0]  = '{1'b1, 1'b0, 4'd0, pk(0, 1, 0, 0, 0)};
    tbl[1]  = '{1'b0, 1'b0, 4'd0, pk(0, 1, 0, 0, 0)};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, pk(0, 1, 0, 0, 0)};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, pk(1, 1, 0, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, 4'd0, pk(0, 1, 0, 0, 0)};
    tbl[5]  = '{1'b0, 1'b0, 4'd5, pk(0, 1, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b0, 4'd3, pk(0, 1, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, 4'd0, pk(0, 0, 1, 0, 1)};
    tbl[8]  = '{1'b0, 1'b0, 4'd0, pk(0, 0, 0, 0, 1)};
    tbl[9]  = '{1'b1, 1'b0, 4'd0, pk(0, 1, 0, 0, 1)};
    tbl[10] = '{1'b0, 1'b1, 4'd0, pk(0, 0, 0, 0, 1)};
    tbl[11] = '{1'b1, 1'b1, 4'd0, pk(0, 1, 0, 0, 1)};
    tbl[12] = '{1'b0, 1'b1, 4'd0, pk(0, 0, 0, 0, 1)};
    tbl[13] = '{1'b1, 1'b0, 4'd0, pk(0, 1, 0, 0, 1)};
    tbl[14] = '{1'b0, 1'b0, 4'd0, pk(0, 1, 0, 0, 1)};
    tbl[15] = '{1'b0, 1'b0, 4'd0, pk(0, 1, 0, 0, 1)};
    tbl[16] = '{1'b0, 1'b0, 4'd0, pk(1, 1, 0, 0, 1)};
    tbl[17] = '{1'b0, 1'b1, 4'd0, pk(0, 0, 0, 0, 1)};

    rst_n = 1'b0;
    clear_inputs();
    ren_a = 1'b0; ren_b = 1'b0; load_a = 15; load_b = 15;
    rv_a = 0; rv_b = 0; man_a = 4'd0; man_b = 4'd0;
    drive_cdi();
    m_a = mdl_rst();
    m_b = mdl_rst();
    #1;
    check("reset_a", act_a(), pk(0, 0, 0, 0, 0));
    check("reset_b", act_b(), pk(0, 0, 0, 0, 0));
    tick();
    tick();
    #3 rst_n = 1'b1;

    // Vector table on the single-shot instance.
    for (int i = 0; i < 18; i++) begin
      ifa.go = tbl[i].go;
      ifa.abort = tbl[i].abort;
      man_a = tbl[i].cdi;
      drive_cdi();
      tick();
      check($sformatf("vec%0d", i), act_a(), tbl[i].exp);
    end
    clear_inputs();
    man_a = 4'd0;
    drive_cdi();

    // Nominal run with the responder loading 15 after the start pulse.
    ren_a = 1'b1; load_a = 15; rv_a = 0; drive_cdi();
    ifa.go = 1'b1; tick(); ifa.go = 1'b0;
    first_done = -1; ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k <= 5) check($sformatf("nom_start_e%0d", k), 32'(ifa.count_down_start), 32'(k == 3));
      if (ifa.done) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
    end
    check("nom_done_edge", first_done, 20);
    check("nom_done_count", ndone, 1);
    check("nom_after", act_a(), pk(0, 0, 0, 0, 2));

    // Timeout: counter never leaves zero.
    ren_a = 1'b0; man_a = 4'd0; rv_a = 0; drive_cdi();
    ifa.go = 1'b1; tick(); ifa.go = 1'b0;
    first_err = -1; npulse = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ifa.count_down_start) npulse++;
      if (ifa.err && first_err < 0) first_err = k;
    end
    check("to_err_edge", first_err, 24);
    check("to_pulses", npulse, 1);
    ifa.go = 1'b1; ifa.abort = 1'b1;
    repeat (3) tick();
    check("err_ignores_go", act_a(), pk(0, 0, 0, 1, 2));
    ifa.go = 1'b0; ifa.abort = 1'b0;
    ifa.clear_err = 1'b1; tick(); ifa.clear_err = 1'b0;
    check("clear_err", act_a(), pk(0, 0, 0, 0, 2));
    ifa.go = 1'b1; tick(); ifa.go = 1'b0;
    check("go_after_clear", act_a(), pk(0, 1, 0, 0, 2));
    ifa.abort = 1'b1; tick(); ifa.abort = 1'b0;
    check("abort_gap", act_a(), pk(0, 0, 0, 0, 2));

    // Abort in RUN while the counter shows 9.
    ren_a = 1'b1; rv_a = 0; drive_cdi();
    ifa.go = 1'b1; tick(); ifa.go = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (ifa.count_down_in == 4'd9) found = 1'b1;
    end
    check("abort_reach9", 32'(found), 32'd1);
    ifa.abort = 1'b1; tick(); ifa.abort = 1'b0;
    check("abort_idle", act_a(), pk(0, 0, 0, 0, 2));
    ndone = 0;
    repeat (25) begin
      tick();
      if (ifa.done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_runs", act_a(), pk(0, 0, 0, 0, 2));

    // Asynchronous reset in the middle of RUN.
    ifa.go = 1'b1; tick(); ifa.go = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick();
      if (ifa.count_down_in == 4'd9) found = 1'b1;
    end
    check("rst_reach9", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    m_a = mdl_rst();
    m_b = mdl_rst();
    #1;
    check("async_rst_a", act_a(), pk(0, 0, 0, 0, 0));
    check("async_rst_b", act_b(), pk(0, 0, 0, 0, 0));
    ren_a = 1'b0; rv_a = 0; drive_cdi();
    tick();
    tick();
    #3 rst_n = 1'b1;
    repeat (5) tick();
    check("post_rst_idle", act_a(), pk(0, 0, 0, 0, 0));

    // Auto-repeat: two runs, stop during the second DONE.
    ren_b = 1'b1; load_b = 6; rv_b = 0; drive_cdi();
    ifb.go = 1'b1; tick(); ifb.go = 1'b0;
    npulse = 0; ndone = 0;
    for (int k = 1; k <= 150; k++) begin
      tick();
      if (ifb.count_down_start) npulse++;
      if (ifb.done) begin
        ndone++;
        ifb.stop = (ndone == 2);
      end else begin
        ifb.stop = 1'b0;
      end
    end
    check("ar_pulses", npulse, 2);
    check("ar_dones", ndone, 2);
    check("ar_final", act_b(), pk(0, 0, 0, 0, 2));

    // Saturation of the run counter.
    load_b = 1; rv_b = 0; drive_cdi();
    ifb.go = 1'b1; tick(); ifb.go = 1'b0;
    ndone = 0; r252 = -1;
    for (int k = 0; k < 4000 && ndone < 256; k++) begin
      tick();
      if (ifb.done) begin
        ndone++;
        if (ndone == 252) r252 = int'(ifb.runs);
        if (ndone == 256) ifb.stop = 1'b1;
      end else begin
        ifb.stop = 1'b0;
      end
    end
    check("sat_runs_254", r252, 254);
    check("sat_done_count", ndone, 256);
    tick();
    ifb.stop = 1'b0;
    check("sat_hold_255", act_b(), pk(0, 0, 0, 0, 255));

    // Random traffic on both instances, compared to the model every cycle.
    ren_a = 1'b0; ren_b = 1'b0;
    zp = 50;
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(2))
          0: zp = 10;
          1: zp = 50;
          default: zp = 97;
        endcase
      end
      ifa.go = ($urandom_range(3) == 0);
      ifa.stop = ($urandom_range(2) == 0);
      ifa.abort = ($urandom_range(19) == 0);
      ifa.clear_err = ($urandom_range(7) == 0);
      ifb.go = ($urandom_range(3) == 0);
      ifb.stop = ($urandom_range(2) == 0);
      ifb.abort = ($urandom_range(19) == 0);
      ifb.clear_err = ($urandom_range(7) == 0);
      man_a = (int'($urandom_range(99)) < zp) ? 4'd0 : 4'($urandom_range(15, 1));
      man_b = (int'($urandom_range(99)) < zp) ? 4'd0 : 4'($urandom_range(15, 1));
      drive_cdi();
      tick();
    end
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
